// File: rtl/disp_mode_if.sv
// Board-control and display-configuration bundle for disp_mode_ctrl.
// slave is the controller side; master is the board/timing side.
interface disp_mode_if;
   logic       frame_start;
   logic       BTN0;
   logic       BTN1;
   logic       BTN2;
   logic       rot_A;
   logic       rot_B;
   logic       rot_dwn;
   logic       SW3;
   logic       demo_en;
   logic [2:0] pattn;
   logic [2:0] pattn_scal;
   logic [3:0] rot_indx;
   logic       cfg_update;
   logic [7:0] LED;

   modport slave (
      input  frame_start, BTN0, BTN1, BTN2,
      input  rot_A, rot_B, rot_dwn, SW3, demo_en,
      output pattn, pattn_scal, rot_indx,
      output cfg_update, LED
   );

   modport master (
      output frame_start, BTN0, BTN1, BTN2,
      output rot_A, rot_B, rot_dwn, SW3, demo_en,
      input  pattn, pattn_scal, rot_indx,
      input  cfg_update, LED
   );
endinterface

// File: rtl/disp_mode_ctrl.sv
// Display-mode controller: debounced board controls feed pending
// registers that are committed to the active outputs on frame_start.
module disp_mode_ctrl #(
   parameter logic [19:0] DEB_MAX     = 20'hFFFFE,
   parameter int unsigned DEMO_FRAMES = 120
) (
   input  logic       clk,
   input  logic       reset,
   disp_mode_if.slave io
);
   localparam logic [7:0] DEMO_N = DEMO_FRAMES[7:0];

   logic        a_s1_q, a_s2_q, b_s1_q, b_s2_q, d_s1_q, d_s2_q;
   logic        deb_a_q, deb_a_d, deb_b_q, deb_b_d, deb_a_dly_q;
   logic [19:0] cnt_q, cnt_d;
   logic        at_max_q, at_max, press, step, btn_any;
   logic [2:0]  pend_rot_q, pend_rot_d;
   logic [2:0]  pend_scal_q, pend_scal_d;
   logic [2:0]  pend_pattn_q, pend_pattn_d;
   logic [7:0]  demo_cnt_q, demo_cnt_d;
   logic [2:0]  pattn_q, pattn_d, scal_q, scal_d, rot_q, rot_d;
   logic        cfg_q, cfg_d;

   always_comb begin
      deb_a_d      = deb_a_q;
      deb_b_d      = deb_b_q;
      cnt_d        = cnt_q;
      pend_rot_d   = pend_rot_q;
      pend_scal_d  = pend_scal_q;
      pend_pattn_d = pend_pattn_q;
      demo_cnt_d   = demo_cnt_q;
      pattn_d      = pattn_q;
      scal_d       = scal_q;
      rot_d        = rot_q;
      cfg_d        = 1'b0;

      // deb_a only moves on A==B, deb_b only on A!=B
      if (a_s2_q && b_s2_q)        deb_a_d = 1'b1;
      else if (!a_s2_q && !b_s2_q) deb_a_d = 1'b0;
      if (!a_s2_q && b_s2_q)       deb_b_d = 1'b1;
      else if (a_s2_q && !b_s2_q)  deb_b_d = 1'b0;

      step = !deb_a_q && deb_a_dly_q;
      if (step)
         pend_rot_d = deb_b_q ? pend_rot_q - 3'd1
                              : pend_rot_q + 3'd1;

      at_max = (cnt_q == DEB_MAX);
      press  = at_max && !at_max_q;
      if (d_s2_q && !at_max)      cnt_d = cnt_q + 20'd1;
      else if (!d_s2_q && at_max) cnt_d = '0;

      if (press) begin
         if (io.SW3 && pend_scal_q < 3'd5)
            pend_scal_d = pend_scal_q + 3'd1;
         else if (!io.SW3 && pend_scal_q > 3'd1)
            pend_scal_d = pend_scal_q - 3'd1;
      end

      btn_any = io.BTN0 || io.BTN1 || io.BTN2;
      if (!io.demo_en || btn_any) begin
         demo_cnt_d = '0;
      end else if (io.frame_start) begin
         if (demo_cnt_q + 8'd1 == DEMO_N) begin
            demo_cnt_d = '0;
            unique case (pend_pattn_q)
               3'b001:  pend_pattn_d = 3'b010;
               3'b010:  pend_pattn_d = 3'b100;
               default: pend_pattn_d = 3'b001;
            endcase
         end else begin
            demo_cnt_d = demo_cnt_q + 8'd1;
         end
      end

      priority case (1'b1)
         io.BTN0: pend_pattn_d = 3'b001;
         io.BTN1: pend_pattn_d = 3'b010;
         io.BTN2: pend_pattn_d = 3'b100;
         default: ;
      endcase

      if (io.frame_start) begin
         pattn_d = pend_pattn_q;
         scal_d  = pend_scal_q;
         rot_d   = pend_rot_q;
         cfg_d   = {pend_pattn_q, pend_scal_q, pend_rot_q}
                   != {pattn_q, scal_q, rot_q};
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         a_s1_q       <= 1'b1;
         a_s2_q       <= 1'b1;
         b_s1_q       <= 1'b1;
         b_s2_q       <= 1'b1;
         d_s1_q       <= 1'b0;
         d_s2_q       <= 1'b0;
         deb_a_q      <= 1'b1;
         deb_b_q      <= 1'b1;
         deb_a_dly_q  <= 1'b1;
         cnt_q        <= '0;
         at_max_q     <= 1'b0;
         pend_rot_q   <= '0;
         pend_scal_q  <= '0;
         pend_pattn_q <= '0;
         demo_cnt_q   <= '0;
         pattn_q      <= '0;
         scal_q       <= '0;
         rot_q        <= '0;
         cfg_q        <= 1'b0;
      end else begin
         a_s1_q       <= io.rot_A;
         a_s2_q       <= a_s1_q;
         b_s1_q       <= io.rot_B;
         b_s2_q       <= b_s1_q;
         d_s1_q       <= io.rot_dwn;
         d_s2_q       <= d_s1_q;
         deb_a_q      <= deb_a_d;
         deb_b_q      <= deb_b_d;
         deb_a_dly_q  <= deb_a_q;
         cnt_q        <= cnt_d;
         at_max_q     <= at_max;
         pend_rot_q   <= pend_rot_d;
         pend_scal_q  <= pend_scal_d;
         pend_pattn_q <= pend_pattn_d;
         demo_cnt_q   <= demo_cnt_d;
         pattn_q      <= pattn_d;
         scal_q       <= scal_d;
         rot_q        <= rot_d;
         cfg_q        <= cfg_d;
      end
   end

   assign io.pattn      = pattn_q;
   assign io.pattn_scal = scal_q;
   assign io.rot_indx   = {1'b0, rot_q};
   assign io.cfg_update = cfg_q;
   assign io.LED        = {1'b0, rot_q, 1'b0, scal_q};
endmodule

// File: tb/tb_disp_mode_ctrl.sv
// Self-checking bench for disp_mode_ctrl against a transaction-level
// model of pending/active display configuration.
module tb_disp_mode_ctrl;
   localparam logic [19:0] DEB = 20'd200;
   localparam int          DF  = 3;

   logic clk = 1'b0;
   logic reset;
   int   n_vec = 0;
   int   n_err = 0;

   disp_mode_if io ();

   disp_mode_ctrl #(.DEB_MAX(DEB), .DEMO_FRAMES(DF)) dut (
      .clk   (clk),
      .reset (reset),
      .io    (io)
   );

   always #5 clk = ~clk;

   int m_pp, m_ps, m_pr;
   int m_ap, m_as, m_ar;
   int m_cnt;
   int m_cfg;

   task automatic chk(input string tag, input logic [7:0] obs,
                      input logic [7:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_out(input string tag);
      logic [7:0] led;
      led = 8'((m_ar << 4) | m_as);
      chk({tag, ".pattn"}, {5'd0, io.pattn}, 8'(m_ap));
      chk({tag, ".scal"}, {5'd0, io.pattn_scal}, 8'(m_as));
      chk({tag, ".rot"}, {4'd0, io.rot_indx}, 8'(m_ar));
      chk({tag, ".led"}, io.LED, led);
      chk({tag, ".cfg"}, {7'd0, io.cfg_update}, 8'(m_cfg));
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic model_reset();
      m_pp = 0; m_ps = 0; m_pr = 0;
      m_ap = 0; m_as = 0; m_ar = 0;
      m_cnt = 0; m_cfg = 0;
   endtask

   function automatic int next_pat(input int p);
      if (p == 1) return 2;
      if (p == 2) return 4;
      return 1;
   endfunction

   task automatic commit_model();
      m_cfg = (m_ap != m_pp || m_as != m_ps || m_ar != m_pr) ? 1 : 0;
      m_ap = m_pp; m_as = m_ps; m_ar = m_pr;
      if (io.demo_en) begin
         m_cnt++;
         if (m_cnt == DF) begin
            m_cnt = 0;
            m_pp = next_pat(m_pp);
         end
      end
   endtask

   task automatic do_frame(input string tag);
      io.frame_start = 1'b1;
      @(negedge clk);
      io.frame_start = 1'b0;
      commit_model();
      check_out(tag);
      m_cfg = 0;
      tick(2);
   endtask

   task automatic cw();
      io.rot_B = 1'b0; tick(4);
      io.rot_A = 1'b0; tick(4);
      io.rot_A = 1'b1; tick(4);
      io.rot_B = 1'b1; tick(6);
      m_pr = (m_pr + 1) % 8;
   endtask

   task automatic ccw();
      io.rot_A = 1'b0; tick(4);
      io.rot_B = 1'b0; tick(4);
      io.rot_B = 1'b1; tick(4);
      io.rot_A = 1'b1; tick(6);
      m_pr = (m_pr + 7) % 8;
   endtask

   task automatic push();
      for (int i = 0; i < 50; i++) begin
         io.rot_dwn = 1'($urandom_range(0, 1));
         tick(1);
      end
      io.rot_dwn = 1'b1; tick(int'(DEB) + 8);
      io.rot_dwn = 1'b0; tick(8);
      if (io.SW3 && m_ps < 5)       m_ps++;
      else if (!io.SW3 && m_ps > 1) m_ps--;
   endtask

   task automatic button(input int k);
      io.BTN0 = (k == 0); io.BTN1 = (k == 1); io.BTN2 = (k == 2);
      tick(1);
      io.BTN0 = 1'b0; io.BTN1 = 1'b0; io.BTN2 = 1'b0;
      m_pp = (k == 0) ? 1 : (k == 1) ? 2 : 4;
      m_cnt = 0;
      tick(1);
   endtask

   task automatic set_demo(input logic v);
      io.demo_en = v;
      if (!v) m_cnt = 0;
      tick(1);
   endtask

   task automatic async_reset(input string tag);
      reset = 1'b0;
      #1;
      model_reset();
      check_out(tag);
      tick(3);
      reset = 1'b1;
      tick(2);
   endtask

   initial begin
      reset = 1'b0;
      io.frame_start = 1'b0;
      io.BTN0 = 1'b0; io.BTN1 = 1'b0; io.BTN2 = 1'b0;
      io.rot_A = 1'b1; io.rot_B = 1'b1; io.rot_dwn = 1'b0;
      io.SW3 = 1'b1; io.demo_en = 1'b0;
      model_reset();

      tick(5);
      check_out("rst_hold");
      tick(5);
      reset = 1'b1;
      tick(2);
      for (int i = 0; i < 3; i++) do_frame("idle");

      for (int i = 0; i < 8; i++) begin
         cw();
         do_frame("rot_cw");
      end
      ccw();
      do_frame("rot_ccw");

      io.SW3 = 1'b1;
      for (int i = 0; i < 7; i++) begin
         push();
         do_frame("scal_up");
      end
      io.SW3 = 1'b0;
      for (int i = 0; i < 6; i++) push();
      do_frame("scal_dn");

      button(1);
      for (int i = 0; i < 98; i++) begin
         chk("hold.pattn", {5'd0, io.pattn}, 8'(m_ap));
         chk("hold.cfg", {7'd0, io.cfg_update}, 8'd0);
         tick(1);
      end
      do_frame("btn1");
      chk("cfg_one", {7'd0, io.cfg_update}, 8'd0);

      io.rot_B = 1'b0; tick(4);
      io.rot_A = 1'b0; tick(3);
      do_frame("same_cyc");
      m_pr = (m_pr + 1) % 8;
      io.rot_A = 1'b1; tick(4);
      io.rot_B = 1'b1; tick(6);
      do_frame("same_cyc_next");

      async_reset("demo_rst");
      set_demo(1'b1);
      for (int f = 1; f <= 12; f++) begin
         if (f == 4) button(2);
         do_frame("demo");
      end
      set_demo(1'b0);

      for (int n = 0; n < 60; n++) begin
         case ($urandom_range(0, 6))
            0: cw();
            1: ccw();
            2: begin io.SW3 = 1'($urandom_range(0, 1)); push(); end
            3: button(int'($urandom_range(0, 2)));
            4: set_demo(1'($urandom_range(0, 1)));
            default: do_frame("rand");
         endcase
      end
      do_frame("rand_end");

      io.SW3 = 1'b1;
      push();
      async_reset("mid_rst");
      do_frame("mid_rst_after");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
